// File: rtl/mem_map_pkg.sv
// Shared memory map for the instruction/data bus arbiter.
// Holds the region bounds, the one-hot target selects, the arbiter
// FSM state type and a small inclusive range helper.
package mem_map_pkg;

    localparam logic [31:0] IMEM_START = 32'h0000_0000;
    localparam logic [31:0] IMEM_END   = 32'h0000_0FFF;
    localparam logic [31:0] DMEM_START = 32'h0000_1000;
    localparam logic [31:0] DMEM_END   = 32'h0000_2FFF;
    localparam logic [31:0] UART_START = 32'h0000_3000;
    localparam logic [31:0] UART_END   = 32'h0000_3FFF;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_IMEM = 3'b001;
    localparam logic [2:0] SEL_DMEM = 3'b010;
    localparam logic [2:0] SEL_UART = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Both bounds inclusive.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Purely combinational address decode: maps a byte address and access
// type onto a one-hot target select, or flags a decode error
// (unmapped address, store into imem, fetch from uart).
module mem_addr_decode
    import mem_map_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic        is_fetch_i,
    input  logic        is_store_i,
    output logic [2:0]  sel_o,
    output logic        err_o
);

    logic [2:0] region;

    // Region lookup, then access-type legality; an error forces select to none.
    always_comb begin
        region = SEL_NONE;
        if (in_region(addr_i, IMEM_START, IMEM_END)) begin
            region = SEL_IMEM;
        end else if (in_region(addr_i, DMEM_START, DMEM_END)) begin
            region = SEL_DMEM;
        end else if (in_region(addr_i, UART_START, UART_END)) begin
            region = SEL_UART;
        end
        err_o = (region == SEL_NONE)
             || (is_store_i && (region == SEL_IMEM))
             || (is_fetch_i && (region == SEL_UART));
        sel_o = err_o ? SEL_NONE : region;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch, load/store) to one shared bus arbiter with
// round-robin grant and a single outstanding transaction.
// Handshake: gnt is a one-cycle combinational accept while IDLE; the
// request fields are captured on that edge. Exactly one rvalid pulse
// per grant goes back to the owning requester.
// Optional feature: define MEM_BUS_ARB_TIMEOUT_EN to abort accesses that
// see no bus_ack within TIMEOUT_CYCLES cycles of ACCESS.
module mem_bus_arbiter
    import mem_map_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [2:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e  state_q, state_d;
    logic        init_q;       // low in the cycle reset releases: no grant then
    logic        last_if_q;    // 1 when fetch won the most recent grant
    logic        owner_ls_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        we_q, err_q;
    logic [3:0]  be_q;
    logic [2:0]  sel_q;

    logic        gnt_any, timeout;
    logic [31:0] req_addr, req_wdata;
    logic        req_we;
    logic [3:0]  req_be;
    logic [2:0]  dec_sel;
    logic        dec_err;

    // Fields of whichever requester is being granted this cycle.
    always_comb begin
        req_addr  = ls_gnt ? ls_addr : if_addr;
        req_we    = ls_gnt & ls_we;
        req_wdata = ls_gnt ? ls_wdata : 32'h0;
        req_be    = ls_gnt ? ls_be : 4'hF;
    end

    mem_addr_decode u_decode (
        .addr_i     (req_addr),
        .is_fetch_i (if_gnt),
        .is_store_i (req_we),
        .sel_o      (dec_sel),
        .err_o      (dec_err)
    );

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts completed ACCESS cycles; restarts at zero outside ACCESS.
    always_comb begin
        cnt_d   = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
        timeout = (state_q == ACCESS) && !bus_ack && (cnt_q == CNT_LAST);
    end

    // Access cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: decode errors skip the bus and answer directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = dec_err ? RESP : ACCESS;
            ACCESS:  if (bus_ack || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grants, bus drive (zero outside ACCESS) and responses.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if ((state_q == IDLE) && init_q) begin
            if (if_req && ls_req) begin
                ls_gnt = last_if_q;
                if_gnt = !last_if_q;
            end else begin
                ls_gnt = ls_req;
                if_gnt = if_req && !ls_req;
            end
        end
        gnt_any   = if_gnt | ls_gnt;
        bus_sel   = (state_q == ACCESS) ? sel_q   : SEL_NONE;
        bus_addr  = (state_q == ACCESS) ? addr_q  : 32'h0;
        bus_we    = (state_q == ACCESS) & we_q;
        bus_wdata = (state_q == ACCESS) ? wdata_q : 32'h0;
        bus_be    = (state_q == ACCESS) ? be_q    : 4'h0;
        if_rvalid = (state_q == RESP) & !owner_ls_q;
        ls_rvalid = (state_q == RESP) &  owner_ls_q;
        if_rdata  = if_rvalid ? rdata_q : 32'h0;
        ls_rdata  = ls_rvalid ? rdata_q : 32'h0;
        if_err    = if_rvalid & err_q;
        ls_err    = ls_rvalid & err_q;
    end

    // Request capture at grant, response capture on ack or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            last_if_q  <= 1'b1;
            owner_ls_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            sel_q      <= SEL_NONE;
            err_q      <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (gnt_any) begin
                owner_ls_q <= ls_gnt;
                last_if_q  <= if_gnt;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                we_q       <= req_we;
                be_q       <= req_be;
                sel_q      <= dec_sel;
                err_q      <= dec_err;
                rdata_q    <= '0;
            end else if (state_q == ACCESS) begin
                if (bus_ack) begin
                    rdata_q <= we_q ? 32'h0 : bus_rdata;
                    err_q   <= 1'b0;
                end else if (timeout) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: driver tasks push expected grants,
// bus accesses and responses into queues; a negedge monitor pops and
// compares whenever the DUT presents them.
module tb_mem_bus_arbiter;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [3:0]  ls_be = '0;
    logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] if_rdata, ls_rdata, bus_addr, bus_wdata;
    logic [2:0]  bus_sel;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [0:0]  gnt_exp_q[$];   // 1 = ls owner
    logic [35:0] sel_exp_q[$];   // {sel, we, addr}
    logic [33:0] rsp_exp_q[$];   // {owner_ls, err, rdata}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus target model: acks after ack_delay ACCESS cycles; force_ack drives ack outside access.
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    logic [31:0] ack_data = '0;
    logic        force_ack = 1'b0;
    int          wait_cnt = 0;
    always @(negedge clk) begin
        if (bus_sel != 3'b000 && ack_en) begin
            if (wait_cnt >= ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = ack_data;
            end else begin
                bus_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus_ack   = force_ack;
            bus_rdata = force_ack ? 32'hBAD0_BAD0 : 32'h0;
            wait_cnt  = 0;
        end
    end

    // Monitor / scoreboard.
    logic [71:0] prev_bus = '0;
    always @(negedge clk) begin
        if (if_gnt || ls_gnt) begin
            check("gnt_exclusive", {63'h0, if_gnt & ls_gnt}, 64'h0);
            if (gnt_exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_gnt: if_gnt=%0b ls_gnt=%0b, expected none", if_gnt, ls_gnt);
            end else begin
                check("gnt_owner", {63'h0, ls_gnt}, {63'h0, gnt_exp_q.pop_front()});
            end
        end
        if (bus_sel != 3'b000 && prev_bus[71:69] == 3'b000) begin
            if (sel_exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_access: bus_sel=%b addr=0x%0h, expected none", bus_sel, bus_addr);
            end else begin
                check("bus_access", {28'h0, bus_sel, bus_we, bus_addr}, {28'h0, sel_exp_q.pop_front()});
            end
        end else if (bus_sel != 3'b000) begin
            check("bus_stable", {bus_sel, bus_we, bus_addr, bus_be, bus_wdata}, prev_bus);
        end else begin
            check("bus_idle_zero", {59'h0, bus_we, bus_be}, 64'h0);
        end
        prev_bus = {bus_sel, bus_we, bus_addr, bus_be, bus_wdata};
        if (if_rvalid || ls_rvalid) begin
            check("rvalid_exclusive", {63'h0, if_rvalid & ls_rvalid}, 64'h0);
            if (rsp_exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_rvalid: if_rvalid=%0b ls_rvalid=%0b, expected none", if_rvalid, ls_rvalid);
            end else begin
                check("response",
                      {30'h0, ls_rvalid, (ls_rvalid ? ls_err : if_err), (ls_rvalid ? ls_rdata : if_rdata)},
                      {30'h0, rsp_exp_q.pop_front()});
            end
        end
    end

    // One complete transaction from a single requester.
    task automatic txn(input logic is_ls, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [2:0] exp_sel, input logic exp_err,
                       input logic [31:0] exp_rdata, input int exp_lat);
        bit got;
        int lat;
        gnt_exp_q.push_back(is_ls);
        if (exp_sel != 3'b000) sel_exp_q.push_back({exp_sel, we, addr});
        rsp_exp_q.push_back({is_ls, exp_err, exp_rdata});
        @(posedge clk); #1;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_be = be;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_ls ? ls_gnt : if_gnt) begin got = 1; break; end
        end
        check("gnt_wait", {63'h0, got}, 64'h1);
        @(posedge clk); #1;
        // Scramble dropped inputs: the DUT must work from its captured copy.
        ls_req = 1'b0; if_req = 1'b0;
        ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom); ls_be = 4'($urandom);
        if_addr = $urandom;
        got = 0; lat = 0;
        for (int i = 1; i <= TO + 10; i++) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) begin got = 1; lat = i; break; end
        end
        check("rvalid_wait", {63'h0, got}, 64'h1);
        check("gnt_to_rvalid_latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check("rvalid_one_cycle", {62'h0, if_rvalid, ls_rvalid}, 64'h0);
    endtask

    task automatic count_rvalids(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) cnt++;
        end
    endtask

    logic [31:0] bnd_addr[5] = '{32'h0FFF, 32'h1000, 32'h2FFF, 32'h3000, 32'h3FFF};
    logic [2:0]  bnd_sel[5]  = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

    // Directed stimulus.
    initial begin
        int cnt;
        bit got;
        // Contention from reset: both requesters held high.
        if_req = 1'b1; if_addr = 32'h0000_0040;
        ls_req = 1'b1; ls_addr = 32'h0000_1000; ls_we = 1'b0; ls_be = 4'hF;
        ack_data = 32'h1111_2222;
        repeat (3) @(negedge clk);
        check("reset_outputs", {49'h0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err,
                                bus_sel, bus_we, bus_be}, 64'h0);
        for (int k = 0; k < 2; k++) begin
            gnt_exp_q.push_back(1'b1);
            gnt_exp_q.push_back(1'b0);
            sel_exp_q.push_back({3'b010, 1'b0, 32'h0000_1000});
            sel_exp_q.push_back({3'b001, 1'b0, 32'h0000_0040});
            rsp_exp_q.push_back({1'b1, 1'b0, 32'h1111_2222});
            rsp_exp_q.push_back({1'b0, 1'b0, 32'h1111_2222});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("no_gnt_at_reset_release", {62'h0, if_gnt, ls_gnt}, 64'h0);
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) cnt++;
        end
        check("contention_responses", 64'(cnt), 64'd4);
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;

        // Single load.
        ack_data = 32'hDEAD_BEEF;
        txn(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 3'b010, 1'b0, 32'hDEAD_BEEF, 2);

        // Decode errors.
        txn(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, 3'b000, 1'b1, 32'h0, 1);
        txn(1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 3'b000, 1'b1, 32'h0, 1);
        txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 3'b000, 1'b1, 32'h0, 1);

        // Region boundaries.
        for (int k = 0; k < 5; k++) begin
            ack_data = 32'hA500_0000 | bnd_addr[k];
            txn(1'b1, 1'b0, bnd_addr[k], 32'h0, 4'hF, bnd_sel[k], 1'b0, 32'hA500_0000 | bnd_addr[k], 2);
        end

        // Stores return zero data; fetch from dmem; slow ack.
        ack_data = 32'h7777_8888;
        txn(1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'b0011, 3'b010, 1'b0, 32'h0, 2);
        txn(1'b1, 1'b1, 32'h0000_3004, 32'h0000_0041, 4'b0001, 3'b100, 1'b0, 32'h0, 2);
        txn(1'b0, 1'b0, 32'h0000_1800, 32'h0, 4'hF, 3'b010, 1'b0, 32'h7777_8888, 2);
        ack_delay = 3;
        ack_data = 32'h0BAD_F00D;
        txn(1'b0, 1'b0, 32'h0000_0FFC, 32'h0, 4'hF, 3'b001, 1'b0, 32'h0BAD_F00D, 5);
        ack_delay = 0;

        // Ack while idle is ignored.
        @(posedge clk); #1;
        force_ack = 1'b1;
        count_rvalids(3, cnt);
        force_ack = 1'b0;
        check("idle_ack_ignored", 64'(cnt), 64'd0);

        // Reset in the middle of a uart access.
        ack_en = 1'b0;
        gnt_exp_q.push_back(1'b1);
        sel_exp_q.push_back({3'b100, 1'b0, 32'h0000_3008});
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_3008;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_sel == 3'b100) begin got = 1; break; end
            if (ls_gnt) begin @(posedge clk); #1; ls_req = 1'b0; end
        end
        ls_req = 1'b0;
        check("uart_access_seen", {63'h0, got}, 64'h1);
        #2 rst_n = 1'b0;
        #1 check("reset_async_outputs",
                 {21'h0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, bus_sel, bus_we, bus_be, bus_addr},
                 64'h0);
        check("reset_async_data", {if_rdata, ls_rdata | bus_wdata}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_en = 1'b1;
        count_rvalids(5, cnt);
        check("no_rvalid_after_reset", 64'(cnt), 64'd0);
        ack_data = 32'h5555_AAAA;
        txn(1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'hF, 3'b010, 1'b0, 32'h5555_AAAA, 2);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Timeout on a uart load, then a late ack.
        ack_en = 1'b0;
        txn(1'b1, 1'b0, 32'h0000_3010, 32'h0, 4'hF, 3'b100, 1'b1, 32'h0, TO + 1);
        force_ack = 1'b1;
        count_rvalids(3, cnt);
        force_ack = 1'b0;
        ack_en = 1'b1;
        check("late_ack_ignored", 64'(cnt), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("queues_drained", 64'(gnt_exp_q.size() + sel_exp_q.size() + rsp_exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles a bus access waits for bus_ack before it is aborted.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- if_req  in  1  fetch request; read only.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetch read data.
- if_err  out  1  fetch response is an error.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  32  load/store byte address.
- ls_wdata  in  32  store data.
- ls_be  in  4  store byte enables.
- ls_gnt  out  1  load/store request accepted.
- ls_rvalid  out  1  load/store response valid.
- ls_rdata  out  32  load data.
- ls_err  out  1  load/store response is an error.
- bus_sel  out  3  one-hot target select: [0] imem, [1] dmem, [2] uart.
- bus_addr  out  32  shared bus address.
- bus_we  out  1  shared bus write strobe.
- bus_wdata  out  32  shared bus write data.
- bus_be  out  4  shared bus byte enables.
- bus_rdata  in  32  target read data, valid with bus_ack.
- bus_ack  in  1  target completes the access.

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-004 SHALL raise if_gnt or ls_gnt combinationally, only in IDLE, for exactly one requester per cycle.
REQ-005 SHALL arbitrate round-robin: when both requests are present, grant the requester not granted last; the pointer resets to fetch-last, so ls wins the first contention.
REQ-006 SHALL capture addr, we, wdata and be into registers at the gnt edge; the requester may change or drop its inputs afterwards.
REQ-007 SHALL decode the captured address as follows:
- imem: 0x0000_0000–0x0000_0FFF.
- dmem: 0x0000_1000–0x0000_2FFF.
- uart: 0x0000_3000–0x0000_3FFF.
- Both bounds are inclusive.
REQ-008 SHALL treat the following as a decode error: an unmapped address, an ls store to imem, or a fetch to uart.
REQ-009 SHALL, on a decode error, move IDLE->RESP and assert rvalid with err=1 and rdata=0 in the cycle after gnt; bus_sel stays 0 and no bus cycle occurs.
REQ-010 SHALL, on a valid decode, move IDLE->ACCESS and drive bus_sel, bus_addr, bus_we, bus_wdata and bus_be from registers, held stable throughout ACCESS.
REQ-011 SHALL, in ACCESS, latch bus_rdata and move to RESP on the first cycle bus_ack=1; rvalid and err=0 follow one cycle after the ack cycle (minimum latency gnt->rvalid is 2 cycles).
REQ-012 SHALL, in RESP, assert rvalid for exactly one cycle to the owning requester only, then return to IDLE; the next gnt is possible in the cycle after RESP.
REQ-013 SHALL return rdata=0 for stores.
REQ-014 SHALL ignore bus_ack outside ACCESS.
REQ-015 SHALL keep at most one transaction outstanding; requests arriving outside IDLE wait without gnt.
REQ-016 SHALL hold bus_sel, bus_we and bus_be at 0 whenever not in ACCESS.

Reset
REQ-017 SHALL, on rst_n low at any time including mid-transaction, immediately:
- force state IDLE and reset the arbitration pointer.
- clear all outputs to 0.
- drop any in-flight transaction with no response.
REQ-018 SHALL grant no request in the cycle rst_n deasserts.

Configuration
REQ-019 SHALL, when macro MEM_BUS_ARB_TIMEOUT_EN is defined, count ACCESS cycles with a counter of width $clog2(TIMEOUT_CYCLES+1); if bus_ack has not arrived after TIMEOUT_CYCLES cycles, abort to RESP with err=1 and rdata=0, deassert bus_sel, and ignore any later ack.
REQ-020 SHALL, without MEM_BUS_ARB_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely.

Structure
REQ-021 SHALL take from shared package mem_map_pkg:
- the region start/end constants.
- the one-hot select encodings.
- the FSM state typedef.
REQ-022 SHALL place the address decode in one sub-module, mem_addr_decode (address and access type in; select and error out; purely combinational).

Verification
REQ-023 Single load: ls load 0x1004, bus_ack in the cycle after gnt with rdata 0xDEADBEEF -> bus_sel=010; ls_rvalid=1, ls_rdata=0xDEADBEEF, ls_err=0 two cycles after gnt.
REQ-024 Contention: if_req and ls_req held high continuously from reset -> grant order ls, if, ls, if; each rvalid goes only to its owner.
REQ-025 Decode errors:
- ls store to 0x0000_0100 -> ls_err=1 with no bus_sel.
- fetch from 0x3000 -> if_err=1.
- load from 0x4000 -> ls_err=1.
REQ-026 Boundaries: loads to 0x0FFF, 0x1000, 0x2FFF, 0x3000 and 0x3FFF -> bus_sel = 001, 010, 010, 100 and 100 respectively.
REQ-027 Reset mid-access: rst_n low in ACCESS with uart selected -> all outputs 0 asynchronously; no rvalid after release; a new request is granted normally.
REQ-028 Timeout (with MEM_BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): uart load, no ack -> ls_err=1 in the cycle after the 4th ACCESS cycle; a late ack is ignored.
